// File: rtl/vedic_pkg.sv
// Shared widths, FSM state encoding and step-to-shift lookup for the Vedic sequential multiplier.
package vedic_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned PROD_W = 64;

    localparam logic [1:0] LAST_STEP = 2'd3;

    // Partial-product alignment per step: aL*bL, aH*bL, aL*bH, aH*bH.
    localparam logic [5:0] STEP_SHIFT [0:3] = '{6'd0, 6'd16, 6'd16, 6'd32};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vedic32_seq_mult_if.sv
// Operand/result handshake bundle for vedic32_seq_mult; master drives operands, slave is the multiplier.
interface vedic32_seq_mult_if;

    logic                          in_valid;
    logic                          in_ready;
    logic [vedic_pkg::OP_W-1:0]    a;
    logic [vedic_pkg::OP_W-1:0]    b;
    logic                          out_valid;
    logic                          out_ready;
    logic [vedic_pkg::PROD_W-1:0]  prod;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, prod
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, prod
    );

endinterface

// File: rtl/vedic16x16.sv
// Combinational 16x16 Vedic (Urdhva) multiplier built from four 8x8 vertical/crosswise products.
module vedic16x16
    import vedic_pkg::*;
(
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    input  logic                ground,
    output logic [OP_W-1:0]     prod,
    output logic                overflow
);

    logic [15:0] w_ll;
    logic [15:0] w_hl;
    logic [15:0] w_lh;
    logic [15:0] w_hh;
    logic [16:0] w_mid;
    logic [32:0] w_sum;

    assign w_ll  = {8'b0, a[7:0]}  * {8'b0, b[7:0]};
    assign w_hl  = {8'b0, a[15:8]} * {8'b0, b[7:0]};
    assign w_lh  = {8'b0, a[7:0]}  * {8'b0, b[15:8]};
    assign w_hh  = {8'b0, a[15:8]} * {8'b0, b[15:8]};

    // Crosswise terms share weight 2^8; vertical terms concatenate without overlap.
    assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};
    assign w_sum = {1'b0, w_hh, w_ll} + {8'b0, w_mid, 8'b0} + {32'b0, ground};

    assign prod     = w_sum[31:0];
    assign overflow = w_sum[32];

endmodule

// File: rtl/vedic32_seq_mult.sv
// 32x32 unsigned sequential multiplier: four steps through one shared vedic16x16.
// Define VEDIC32_PP_PIPE_EN to register the partial product before the accumulator adder.
module vedic32_seq_mult
    import vedic_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    vedic32_seq_mult_if.slave   bus
);

    state_t              r_state;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [1:0]          r_step;
    logic [PROD_W-1:0]   r_acc;
    logic [PROD_W-1:0]   r_prod;
    logic                r_out_valid;

    logic [HALF_W-1:0]   w_mul_a;
    logic [HALF_W-1:0]   w_mul_b;
    logic [OP_W-1:0]     w_pp;
    logic [PROD_W-1:0]   w_pp_shifted;
    logic [PROD_W-1:0]   w_add;
    logic                w_accept;
    logic                w_overflow_unused;

    // step[0] picks the high half of a, step[1] the high half of b.
    assign w_mul_a = r_step[0] ? r_a[OP_W-1:HALF_W] : r_a[HALF_W-1:0];
    assign w_mul_b = r_step[1] ? r_b[OP_W-1:HALF_W] : r_b[HALF_W-1:0];

    vedic16x16 u_mul (
        .a        (w_mul_a),
        .b        (w_mul_b),
        .ground   (1'b0),
        .prod     (w_pp),
        .overflow (w_overflow_unused)
    );

    assign w_pp_shifted = {{(PROD_W-OP_W){1'b0}}, w_pp} << STEP_SHIFT[r_step];

    assign w_accept      = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.prod      = r_prod;

`ifdef VEDIC32_PP_PIPE_EN
    logic [PROD_W-1:0]   r_pp;
    logic                r_pp_vld;
    logic                r_drain;

    assign w_add = r_acc + r_pp;
`else
    assign w_add = r_acc + w_pp_shifted;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_step      <= '0;
            r_acc       <= '0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
`ifdef VEDIC32_PP_PIPE_EN
            r_pp        <= '0;
            r_pp_vld    <= 1'b0;
            r_drain     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_step  <= '0;
                        r_acc   <= '0;
                        r_state <= ST_MUL;
`ifdef VEDIC32_PP_PIPE_EN
                        r_pp_vld <= 1'b0;
                        r_drain  <= 1'b0;
`endif
                    end
                end
                ST_MUL: begin
`ifdef VEDIC32_PP_PIPE_EN
                    // Accumulation trails issue by one cycle; a drain cycle folds in the last product.
                    if (r_pp_vld) begin
                        r_acc <= w_add;
                    end
                    r_pp     <= w_pp_shifted;
                    r_pp_vld <= !r_drain;
                    if (r_drain) begin
                        r_prod      <= w_add;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_step == LAST_STEP) begin
                        r_drain <= 1'b1;
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
`else
                    r_acc <= w_add;
                    if (r_step == LAST_STEP) begin
                        r_prod      <= w_add;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_step <= r_step + 2'd1;
                    end
`endif
                end
                ST_DONE: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vedic32_seq_mult.sv
// Directed-vector and regression bench for vedic32_seq_mult (either VEDIC32_PP_PIPE_EN build).
module tb_vedic32_seq_mult;

`ifdef VEDIC32_PP_PIPE_EN
    localparam int unsigned LAT = 6;
`else
    localparam int unsigned LAT = 5;
`endif

    typedef struct {
        logic [31:0]  a;
        logic [31:0]  b;
        logic [63:0]  exp;
        int unsigned  hold;
        bit           garble;
    } vec_t;

    logic clk;
    logic rst;
    int unsigned n_tests;
    int unsigned n_fail;

    vedic32_seq_mult_if bus ();

    vedic32_seq_mult dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    // Entered just after a falling edge; returns just after a falling edge with the block back in IDLE.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic [63:0] texp,
                          input int unsigned hold, input bit garble);
        int unsigned k;
        logic [63:0] held;
        bit ok;
        bus.a         = ta;
        bus.b         = tb_b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", {63'b0, bus.in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        k = 1;
        bus.in_valid = garble;
        while (!bus.out_valid && k < 20) begin
            if (garble) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(negedge clk);
            k++;
        end
        check("latency", 64'(k), 64'(LAT));
        check("prod", bus.prod, texp);
        held = bus.prod;
        ok = 1'b1;
        for (int unsigned i = 0; i < hold; i++) begin
            if (garble) begin
                bus.in_valid = 1'b1;
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(negedge clk);
            if (!bus.out_valid || bus.prod !== held || bus.in_ready) ok = 1'b0;
        end
        if (hold > 0) check("backpressure_stable", {63'b0, ok}, 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_flags", {62'b0, bus.out_valid, bus.in_ready}, 64'b01);
        check("prod_hold_idle", bus.prod, texp);
        bus.out_ready = 1'b0;
    endtask

    vec_t vecs [12];

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit ok;

        vecs[0]  = '{32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, 0,  1'b0};
        vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0,  1'b0};
        vecs[2]  = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 2,  1'b0};
        vecs[3]  = '{32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, 0,  1'b1};
        vecs[4]  = '{32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 0,  1'b0};
        vecs[5]  = '{32'h0000_0001, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF, 1,  1'b0};
        vecs[6]  = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 0,  1'b0};
        vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 0,  1'b1};
        vecs[8]  = '{32'h0001_0001, 32'h0001_0001, 64'h0000_0001_0002_0001, 10, 1'b1};
        vecs[9]  = '{32'hFFFF_0000, 32'hFFFF_0000, 64'hFFFE_0001_0000_0000, 0,  1'b0};
        vecs[10] = '{32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000, 3,  1'b0};
        vecs[11] = '{32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, 0,  1'b0};

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;

        repeat (3) @(negedge clk);
        check("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("reset_in_ready", {63'b0, bus.in_ready}, 64'd0);
        check("reset_prod", bus.prod, 64'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", {63'b0, bus.in_ready}, 64'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, vecs[i].garble);
        end

        // Abort an operation with a one-cycle reset during MUL step 2.
        bus.a = 32'h1111_1111;
        bus.b = 32'h2222_2222;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
        check("abort_in_ready", {63'b0, bus.in_ready}, 64'd0);
        check("abort_prod", bus.prod, 64'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", {63'b0, bus.in_ready}, 64'd1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b0;
        end
        check("abort_no_stale_valid", {63'b0, ok}, 64'd1);
        run_op(32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 0, 1'b0);

        for (int unsigned n = 0; n < 10000; n++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, {32'b0, ra} * {32'b0, rb},
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vedic32_seq_mult.md
VEDIC32_SEQ_MULT -- requirements
Module: vedic32_seq_mult

Interface
REQ-001 Parameter: none; widths fixed at 32-bit operands and 64-bit product, taken from the shared package.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair a/b is valid this cycle.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  32  multiplicand, unsigned.
REQ-007 b  input  32  multiplier, unsigned.
REQ-008 out_valid  output  1  prod holds a completed result.
REQ-009 out_ready  input  1  downstream consumes prod this cycle.
REQ-010 prod  output  64  unsigned product a*b.

Function
REQ-011 Operands SHALL be captured into internal registers on the cycle where in_valid and in_ready are both high; later changes on a/b SHALL have no effect.
REQ-012 FSM states SHALL be IDLE, MUL, DONE.
- IDLE -> MUL on accept.
- MUL -> DONE after the fourth partial-product step.
- DONE -> IDLE on out_valid && out_ready.
REQ-013 MUL SHALL run one shared 16x16 multiplier over exactly four steps, selected by a 2-bit step counter that clears on entry to MUL:
- step 0: aL*bL, shift 0
- step 1: aH*bL, shift 16
- step 2: aL*bH, shift 16
- step 3: aH*bH, shift 32
REQ-014 The 64-bit accumulator SHALL clear on accept, and each step SHALL add its shifted 32-bit partial product modulo 2^64.
REQ-015 The final value SHALL equal a*b exactly; no overflow indication is produced.
REQ-016 Latency without the pipe option: out_valid SHALL rise exactly 5 cycles after the accept edge.
REQ-017 In DONE, out_valid SHALL be high and prod SHALL stay stable until out_ready is sampled high; backpressure of any length SHALL be tolerated.
REQ-018 Outside DONE, out_valid SHALL be 0 and prod SHALL hold its last value.
REQ-019 in_ready SHALL be 0 in MUL and DONE; in_valid in those states SHALL be ignored.
REQ-020 Peak throughput SHALL be one result per 6 cycles (accept, 4x MUL, DONE with out_ready high).
REQ-021 The step counter SHALL not wrap within an operation; it returns to 0 only via accept or reset.

Reset
REQ-022 While rst is high, the block SHALL force the following values:
- state=IDLE, step counter=0, accumulator=0, operand registers=0
- prod=0, out_valid=0, in_ready=0
REQ-023 On the first cycle after rst falls, in_ready SHALL be 1.
REQ-024 rst asserted during MUL or DONE SHALL abandon the operation; no result is emitted and no stale out_valid appears afterwards.

Configuration
REQ-025 Macro VEDIC32_PP_PIPE_EN, when defined, SHALL insert one register stage between the 16x16 multiplier output and the accumulator adder.
REQ-026 With VEDIC32_PP_PIPE_EN defined:
- MUL SHALL last 5 cycles (4 issues plus 1 drain).
- Latency from accept to out_valid SHALL be 6 cycles.
- The results SHALL be identical to the unpiped build.
REQ-027 Without VEDIC32_PP_PIPE_EN, the partial product SHALL feed the adder combinationally, with the timing of REQ-016.

Structure
REQ-028 Shared package vedic_pkg SHALL hold the following:
- the FSM state enum
- OP_W=32, HALF_W=16, PROD_W=64
- the step-to-shift lookup constants
REQ-029 The block SHALL instantiate exactly one existing vedic16x16 as its sub-module, with ground tied to 1'b0 and overflow left unused.
REQ-030 Operand half-select and shift logic SHALL stay inside vedic32_seq_mult; no further sub-modules are used.

Verification
REQ-031 Accept a=0x00000007, b=0x00000006, out_ready=1:
- prod=0x000000000000002A
- out_valid high exactly 5 cycles after accept (6 cycles with the macro).
REQ-032 Accept a=0xFFFFFFFF, b=0xFFFFFFFF -> prod=0xFFFFFFFE00000001 (carry propagation across every step).
REQ-033 Accept a=0x00010000, b=0x00010000 -> prod=0x0000000100000000; accept a=0x0000FFFF, b=0x00010001 -> prod=0x00000000FFFFFFFF.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands:
- prod stays stable and in_ready stays 0 throughout.
- Once out_ready is raised: one handshake, then IDLE, and the new operands are accepted next.
REQ-035 Assert rst for 1 cycle during MUL step 2:
- The outputs match REQ-022.
- out_valid never rises for the aborted operation.
- The next op, 0x00000003*0x00000005, returns 0x000000000000000F.
REQ-036 Random regression of at least 10k unsigned operand pairs with random out_ready, in both macro builds, SHALL match a 64-bit reference model.
